// File: rtl/note_tone_gen_pkg.sv
// -----------------------------------------------------------------------------
// note_tone_pkg
// Shared definitions for the note_tone_gen square-wave voice:
//   CLK_HZ           system clock frequency (50 MHz)
//   NOTE_COUNT       number of playable notes (1..24 = C4..B5)
//   half_period_t    17-bit half period in clock cycles
//   env_state_e      envelope states IDLE / ATTACK / SUSTAIN / RELEASE
//   HALF_PERIOD_LUT  half period per note, round(CLK_HZ / (2 * f_note)),
//                    equal temperament anchored on A4 = 440 Hz (C4 = 261.63 Hz)
//   note_half_period lookup helper; returns 0 for note 0 and invalid indices
// -----------------------------------------------------------------------------
package note_tone_pkg;

  localparam int unsigned CLK_HZ     = 50_000_000;
  localparam int          NOTE_COUNT = 24;

  typedef logic [16:0] half_period_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ATTACK  = 2'd1,
    ST_SUSTAIN = 2'd2,
    ST_RELEASE = 2'd3
  } env_state_e;

  // Index 0 holds note 1 (C4), index 23 holds note 24 (B5).
  localparam half_period_t HALF_PERIOD_LUT [NOTE_COUNT] = '{
    17'd95556, 17'd90193, 17'd85131, 17'd80353, 17'd75843, 17'd71586,
    17'd67569, 17'd63776, 17'd60197, 17'd56818, 17'd53629, 17'd50619,
    17'd47778, 17'd45097, 17'd42566, 17'd40177, 17'd37922, 17'd35793,
    17'd33784, 17'd31888, 17'd30098, 17'd28409, 17'd26815, 17'd25310
  };

  function automatic half_period_t note_half_period(input logic [4:0] n);
    half_period_t hp;
    hp = '0;
    if (n != 5'd0 && n <= 5'(NOTE_COUNT)) begin
      hp = HALF_PERIOD_LUT[n - 5'd1];
    end
    return hp;
  endfunction

endpackage

// File: rtl/note_tone_gen_if.sv
// -----------------------------------------------------------------------------
// note_tone_gen_if
// Note-in / sample-out bundle of the tone generator.
//   note         [4:0]  held note index (0 = none, 1..24 = C4..B5, >24 invalid)
//   sample_tick         one-cycle audio sample strobe
//   sample       [15:0] signed audio sample
//   sample_valid        one-cycle pulse marking a new sample
//   active              envelope not idle
// master: the note/tick source; slave: the generator.
// -----------------------------------------------------------------------------
interface note_tone_gen_if;

  logic        [4:0]  note;
  logic               sample_tick;
  logic signed [15:0] sample;
  logic               sample_valid;
  logic               active;

  modport master (
    output note, sample_tick,
    input  sample, sample_valid, active
  );

  modport slave (
    input  note, sample_tick,
    output sample, sample_valid, active
  );

endinterface

// File: rtl/note_tone_gen_divider.sv
// -----------------------------------------------------------------------------
// tone_divider
// Phase counter of the square wave. Counts 0..half_period-1, then wraps and
// flips polarity. restart forces the counter to 0 and polarity positive.
// A half period of 0 (nothing played since reset) freezes the counter.
//   clock        system clock
//   reset        asynchronous active-low reset
//   half_period  half period in clock cycles
//   restart      phase restart strobe
//   polarity     1 = positive half, 0 = negative half
// -----------------------------------------------------------------------------
module tone_divider
  import note_tone_pkg::*;
(
  input  logic         clock,
  input  logic         reset,
  input  half_period_t half_period,
  input  logic         restart,
  output logic         polarity
);

  half_period_t r_count;
  logic         r_polarity;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_count    <= '0;
      r_polarity <= 1'b1;
    end else if (restart) begin
      r_count    <= '0;
      r_polarity <= 1'b1;
    end else if (half_period != '0) begin
      if (r_count >= half_period - 17'd1) begin
        r_count    <= '0;
        r_polarity <= ~r_polarity;
      end else begin
        r_count <= r_count + 17'd1;
      end
    end
  end

  assign polarity = r_polarity;

endmodule

// File: rtl/note_tone_gen.sv
// -----------------------------------------------------------------------------
// note_tone_gen
// Square-wave voice with an attack/sustain/release amplitude envelope.
// Build option: define NOTE_TONE_ENVELOPE_EN for the four-state envelope;
// without it the amplitude switches straight between 0 and AMP_MAX and
// ENV_STEP has no effect.
// Parameters:
//   AMP_MAX   sustain amplitude (square-wave magnitude)
//   ENV_STEP  amplitude change per sample_tick in attack/release
// Ports:
//   clock     system clock, rising edge
//   reset     asynchronous active-low reset
//   bus       note_tone_gen_if.slave (note, sample_tick -> sample,
//             sample_valid, active)
// -----------------------------------------------------------------------------
module note_tone_gen
  import note_tone_pkg::*;
#(
  parameter logic [15:0] AMP_MAX  = 16'd8000,
  parameter logic [15:0] ENV_STEP = 16'd40
) (
  input logic            clock,
  input logic            reset,
  note_tone_gen_if.slave bus
);

  localparam logic [16:0] AMP_MAX_W = {1'b0, AMP_MAX};

  logic [4:0]         w_note_eff;
  logic               w_note_on;
  logic               w_restart;
  logic [4:0]         r_note_q;
  half_period_t       r_half_period;
  logic               w_polarity;
  env_state_e         r_state;
  env_state_e         w_state_next;
  logic [16:0]        r_amp;
  logic [16:0]        w_amp_next;
  logic signed [15:0] w_mag;
  logic signed [15:0] w_sample_next;
  logic signed [15:0] r_sample;
  logic               r_sample_valid;
  logic               w_unused_amp_msb;

  // Out-of-range indices behave exactly like "no note".
  assign w_note_eff = (bus.note > 5'(NOTE_COUNT)) ? 5'd0 : bus.note;
  assign w_note_on  = (w_note_eff != 5'd0);
  assign w_restart  = (w_note_eff != r_note_q) && w_note_on;

  // The half period is only replaced by a new nonzero note, so a release
  // keeps sounding at the pitch of the note that was let go.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_note_q      <= 5'd0;
      r_half_period <= '0;
    end else begin
      r_note_q <= w_note_eff;
      if (w_restart) begin
        r_half_period <= note_half_period(w_note_eff);
      end
    end
  end

  tone_divider u_divider (
    .clock       (clock),
    .reset       (reset),
    .half_period (r_half_period),
    .restart     (w_restart),
    .polarity    (w_polarity)
  );

  // FSM process 1: state and amplitude registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_amp   <= '0;
    end else begin
      r_state <= w_state_next;
      r_amp   <= w_amp_next;
    end
  end

`ifdef NOTE_TONE_ENVELOPE_EN
  localparam logic [16:0] STEP_W = {1'b0, ENV_STEP};

  logic [16:0] w_amp_up;
  logic [16:0] w_amp_down;

  // Both operands fit in 16 bits, so the 17-bit sum cannot overflow.
  assign w_amp_up   = (r_amp + STEP_W >= AMP_MAX_W) ? AMP_MAX_W : r_amp + STEP_W;
  assign w_amp_down = (r_amp > STEP_W) ? r_amp - STEP_W : 17'd0;

  // FSM process 2: next state. Note on/off wins over the amplitude-driven
  // transitions; ATTACK/RELEASE end on the amplitude being written this cycle.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:    if (w_note_on) w_state_next = ST_ATTACK;
      ST_ATTACK: begin
        if (!w_note_on)                    w_state_next = ST_RELEASE;
        else if (w_amp_next == AMP_MAX_W)  w_state_next = ST_SUSTAIN;
      end
      ST_SUSTAIN: if (!w_note_on) w_state_next = ST_RELEASE;
      ST_RELEASE: begin
        if (w_note_on)                w_state_next = ST_ATTACK;
        else if (w_amp_next == 17'd0) w_state_next = ST_IDLE;
      end
      default:    w_state_next = ST_IDLE;
    endcase
  end

  // FSM process 3 (amplitude part): ramps move only on sample_tick.
  always_comb begin
    w_amp_next = r_amp;
    case (r_state)
      ST_IDLE:    w_amp_next = 17'd0;
      ST_ATTACK:  if (bus.sample_tick) w_amp_next = w_amp_up;
      ST_SUSTAIN: w_amp_next = AMP_MAX_W;
      ST_RELEASE: if (bus.sample_tick) w_amp_next = w_amp_down;
      default:    w_amp_next = 17'd0;
    endcase
  end
`else
  logic w_unused_env_step;

  // Without ramps the step size is meaningless.
  assign w_unused_env_step = ^ENV_STEP;

  // FSM process 2: next state, only IDLE and SUSTAIN are reachable.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:    if (w_note_on)  w_state_next = ST_SUSTAIN;
      ST_SUSTAIN: if (!w_note_on) w_state_next = ST_IDLE;
      default:    w_state_next = ST_IDLE;
    endcase
  end

  // FSM process 3 (amplitude part): full level while any note is held.
  always_comb begin
    w_amp_next = w_note_on ? AMP_MAX_W : 17'd0;
  end
`endif

  // FSM process 3 (sample part): sign follows the square-wave polarity.
  // The registered amp/polarity are used, so a note change landing on a
  // tick still produces the pre-change sample.
  assign w_unused_amp_msb = r_amp[16];
  assign w_mag            = $signed(r_amp[15:0]);

  always_comb begin
    w_sample_next = 16'sd0;
    if (r_state != ST_IDLE) begin
      w_sample_next = w_polarity ? w_mag : -w_mag;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sample       <= 16'sd0;
      r_sample_valid <= 1'b0;
    end else begin
      r_sample_valid <= bus.sample_tick;
      if (bus.sample_tick) begin
        r_sample <= w_sample_next;
      end
    end
  end

  assign bus.sample       = r_sample;
  assign bus.sample_valid = r_sample_valid;
  assign bus.active       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_note_tone_gen.sv
// -----------------------------------------------------------------------------
// tb_note_tone_gen
// Randomised bench for note_tone_gen. A reference model steps once per clock
// from the held note and tick, pushes the expected sample of every tick into
// a queue, and a negedge monitor pops and compares whenever sample_valid is
// seen. The model follows NOTE_TONE_ENVELOPE_EN like the design does.
// -----------------------------------------------------------------------------
module tb_note_tone_gen;

  localparam int AMP_MAX  = 8000;
  localparam int ENV_STEP = 40;

  // Model state names (bench-local numbering).
  localparam int M_IDLE    = 0;
  localparam int M_ATTACK  = 1;
  localparam int M_SUSTAIN = 2;
  localparam int M_RELEASE = 3;

  logic clk = 1'b0;
  logic rst_n;

  always #10 clk = ~clk;

  note_tone_gen_if bus ();

  note_tone_gen #(
    .AMP_MAX  (16'd8000),
    .ENV_STEP (16'd40)
  ) dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int n_samples = 0;
  int exp_q[$];
  bit exp_active = 1'b0;
  int mon_exp;

  // Reference model state.
  int m_state;
  int m_amp;
  int m_note;
  int m_hp;
  int m_t;     // cycles elapsed since the last phase restart

  // Half period from the equal-tempered frequency, A4 (note 10) = 440 Hz.
  function automatic int ref_half_period(input int n);
    real f;
    f = 440.0 * $pow(2.0, real'(n - 10) / 12.0);
    return $rtoi(50.0e6 / (2.0 * f) + 0.5);
  endfunction

  task automatic model_reset();
    m_state = M_IDLE;
    m_amp   = 0;
    m_note  = 0;
    m_hp    = 0;
    m_t     = 0;
  endtask

  task automatic model_step(input int note_in, input bit tick);
    int ne;
    bit on;
    bit pos;
    int new_amp;
    ne  = (note_in > 24) ? 0 : note_in;
    on  = (ne != 0);
    pos = (m_hp == 0) ? 1'b1 : (((m_t / m_hp) % 2) == 0);
    if (tick) begin
      if (m_state == M_IDLE) exp_q.push_back(0);
      else                   exp_q.push_back(pos ? m_amp : -m_amp);
    end
`ifdef NOTE_TONE_ENVELOPE_EN
    new_amp = m_amp;
    case (m_state)
      M_IDLE: begin
        new_amp = 0;
        if (on) m_state = M_ATTACK;
      end
      M_ATTACK: begin
        if (tick) new_amp = (m_amp + ENV_STEP > AMP_MAX) ? AMP_MAX : m_amp + ENV_STEP;
        if (!on)                     m_state = M_RELEASE;
        else if (new_amp == AMP_MAX) m_state = M_SUSTAIN;
      end
      M_SUSTAIN: begin
        new_amp = AMP_MAX;
        if (!on) m_state = M_RELEASE;
      end
      default: begin
        if (tick) new_amp = (m_amp < ENV_STEP) ? 0 : m_amp - ENV_STEP;
        if (on)                m_state = M_ATTACK;
        else if (new_amp == 0) m_state = M_IDLE;
      end
    endcase
`else
    new_amp = on ? AMP_MAX : 0;
    m_state = on ? M_SUSTAIN : M_IDLE;
`endif
    m_amp = new_amp;
    if (on && ne != m_note) begin
      m_hp = ref_half_period(ne);
      m_t  = 0;
    end else begin
      m_t++;
    end
    m_note = ne;
  endtask

  task automatic check(input string name, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
    end
  endtask

  // Called at posedge+1: outputs now reflect the model's current state.
  task automatic drive_cycle(input int n, input bit tick);
    exp_active      = (m_state != M_IDLE);
    bus.note        = 5'(n);
    bus.sample_tick = tick;
    model_step(n, tick);
    @(posedge clk);
    #1;
  endtask

  task automatic run_seg(input int n, input int len, input int div,
                         input int dense_lo, input int dense_hi);
    bit tick;
    for (int c = 0; c < len; c++) begin
      tick = (c >= dense_lo && c < dense_hi) || ($urandom_range(0, div - 1) == 0);
      drive_cycle(n, tick);
    end
  endtask

  // Monitor: one transaction per sample_valid, plus active every cycle.
  always @(negedge clk) begin
    n_checks++;
    if (bus.active !== exp_active) begin
      n_errors++;
      $display("FAIL active: got %0b expected %0b at %0t", bus.active, exp_active, $time);
    end
    if (bus.sample_valid === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL sample_valid: got unexpected pulse expected none at %0t", $time);
      end else begin
        mon_exp = exp_q.pop_front();
        n_samples++;
        if (int'(bus.sample) != mon_exp) begin
          n_errors++;
          $display("FAIL sample #%0d: got %0d expected %0d at %0t",
                   n_samples, bus.sample, mon_exp, $time);
        end else begin
          $display("sample #%0d: %0d ok", n_samples, bus.sample);
        end
      end
    end
  end

  int rn;
  int rlen;
  int rdiv;

  initial begin
    rst_n           = 1'b0;
    bus.note        = 5'd0;
    bus.sample_tick = 1'b0;
    model_reset();

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_sample", int'(bus.sample), 0);
    check("reset_valid", int'(bus.sample_valid), 0);
    check("reset_active", int'(bus.active), 0);

    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Invalid note behaves as silence.
    run_seg(27, 300, 8, 0, 0);

    // Note 10 held across its first polarity flip, ticks dense around it.
    run_seg(10, 58000, 32, 56800, 56830);

    // Release to idle.
    run_seg(0, 2000, 8, 0, 0);

    // Re-attack during release at a new pitch.
    run_seg(22, 400, 2, 0, 0);
    run_seg(0, 60, 1, 0, 0);
    run_seg(5, 400, 4, 0, 0);

    // Random note sequence.
    for (int s = 0; s < 8; s++) begin
      rn   = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 31));
      rlen = int'($urandom_range(200, 1200));
      case ($urandom_range(0, 2))
        0:       rdiv = 1;
        1:       rdiv = 4;
        default: rdiv = 16;
      endcase
      run_seg(rn, rlen, rdiv, 0, 0);
    end

    // Reset while a note sounds: silence in the same cycle.
    run_seg(10, 500, 4, 0, 0);
    drive_cycle(10, 1'b0);
    drive_cycle(10, 1'b0);
    #4;
    rst_n      = 1'b0;
    exp_active = 1'b0;
    #1;
    check("midreset_sample", int'(bus.sample), 0);
    check("midreset_active", int'(bus.active), 0);
    check("midreset_valid", int'(bus.sample_valid), 0);
    check("midreset_queue", exp_q.size(), 0);
    exp_q.delete();
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Note 10 again straight out of reset.
    run_seg(10, 300, 8, 20, 21);
    run_seg(0, 1500, 4, 0, 0);

    drive_cycle(0, 1'b0);
    drive_cycle(0, 1'b0);
    drive_cycle(0, 1'b0);
    check("queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/note_tone_gen.md
NOTE_TONE_GEN -- requirements
Module: note_tone_gen

Interface
REQ-001 SHALL have parameter AMP_MAX, default 16'd8000: sustain amplitude, signed magnitude of the square wave.
REQ-002 SHALL have parameter ENV_STEP, default 16'd40: amplitude change per sample_tick during attack and release.
REQ-003 SHALL have port clock  input  1  sole clock, rising edge, 50 MHz.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port note  input  5  held note index from the sustain stage; 0 = none, 1..24 = C4..B5, 25..31 invalid.
REQ-006 SHALL have port sample_tick  input  1  one-cycle audio sample strobe, 48 kHz.
REQ-007 SHALL have port sample  output  16  signed audio sample, registered.
REQ-008 SHALL have port sample_valid  output  1  one-cycle pulse marking a new sample.
REQ-009 SHALL have port active  output  1  high whenever the envelope state is not IDLE.

Function
REQ-010 SHALL register note every cycle (note_q); a note change is note != note_q; invalid indices SHALL be treated as 0.
REQ-011 SHALL map notes 1..24 through a half-period LUT of clock cycles: round(50e6 / (2 * 261.63 * 2^((n-1)/12))). Note 10 maps to 56818.
REQ-012 SHALL keep a 17-bit phase counter; on reaching half_period-1 it SHALL wrap to 0 and toggle polarity.
REQ-013 On a change to a nonzero note, the counter SHALL clear to 0, polarity SHALL become positive, and the new half period SHALL be latched.
REQ-014 On a change to 0, the last nonzero half period SHALL be retained, so the release sounds at the last pitch.
REQ-015 The envelope FSM SHALL have states IDLE, ATTACK, SUSTAIN and RELEASE.
REQ-016 IDLE -> ATTACK on a nonzero note.
REQ-017 ATTACK: amp += ENV_STEP per sample_tick, saturating at AMP_MAX; on reaching AMP_MAX the FSM SHALL move to SUSTAIN.
REQ-018 SUSTAIN: amp SHALL hold at AMP_MAX.
REQ-019 ATTACK or SUSTAIN SHALL move to RELEASE when the note goes to 0.
REQ-020 RELEASE: amp -= ENV_STEP per sample_tick, saturating at 0; on reaching 0 the FSM SHALL move to IDLE.
REQ-021 RELEASE -> ATTACK on a nonzero note, starting from the current amp with no reset to 0.
REQ-022 A change from one nonzero note to another nonzero note SHALL restart the phase only; the envelope state SHALL be unchanged.
REQ-023 On sample_tick, the next cycle SHALL present sample = polarity ? +amp : -amp and pulse sample_valid; latency is exactly 1 cycle.
REQ-024 In IDLE, sample SHALL be 0 while sample_valid still pulses on each tick.
REQ-025 When a note change coincides with sample_tick, that sample SHALL use the pre-change amp and polarity; the state change applies from the next cycle.
REQ-026 Arithmetic SHALL be unsigned 17-bit with explicit saturation; amp SHALL never exceed AMP_MAX or go below 0.

Reset
REQ-027 While reset is low, the block SHALL hold: state IDLE, amp 0, counter 0, polarity positive, note_q 0, half period 0, sample 0, sample_valid 0, active 0.
REQ-028 Reset asserted mid-note SHALL silence the output immediately, without a release phase.
REQ-029 Deassertion of reset SHALL be synchronised externally; the block SHALL sample its inputs from the first edge after deassertion.

Configuration
REQ-030 With NOTE_TONE_ENVELOPE_EN defined, the block SHALL implement the full four-state FSM described above.
REQ-031 With NOTE_TONE_ENVELOPE_EN undefined, ATTACK and RELEASE SHALL be absent: amp jumps to AMP_MAX on a nonzero note and to 0 on note 0, and ENV_STEP SHALL be ignored.

Structure
REQ-032 Package note_tone_pkg SHALL hold: the 24-entry half-period LUT, NOTE_COUNT = 24, the envelope state typedef, and CLK_HZ = 50_000_000.
REQ-033 The phase counter SHALL be one sub-module, tone_divider, with inputs half_period, restart and clock; outputs polarity.

Verification
REQ-034 Reset, then note = 10 held: polarity SHALL toggle every 56818 cycles; active SHALL rise 1 cycle after the change.
REQ-035 Note = 10 with ticks every 1042 cycles: amp SHALL rise by 40 per tick and reach 8000 after 200 ticks, then the FSM SHALL move to SUSTAIN.
REQ-036 Note 10 -> 0 during SUSTAIN: amp SHALL fall by 40 per tick to 0, then the FSM SHALL reach IDLE, active SHALL drop, and sample SHALL be 0.
REQ-037 Note = 0 at amp = 2000 in RELEASE, then note = 5: the FSM SHALL enter ATTACK from 2000 and the phase counter SHALL restart at 0.
REQ-038 Note = 27: the block SHALL behave as note 0 and remain in IDLE with sample 0.
REQ-039 Reset pulsed low in SUSTAIN: sample = 0 and active = 0 in the same cycle; repeat with the macro undefined, where the first tick after note = 10 SHALL give sample = +8000.
